paddle_emu_mc: RTL and testbench

Multi-channel paddle emulator that replaces the fixed two-player paddle logic in the core top level. Per channel it converts digital buttons, analog stick Y, analog stick X or a real paddle into a position value. It loads that value into a countdown at each vertical sync rising edge and decrements the countdown at each horizontal sync rising edge. It drives the chip's paddle input pin high while the countdown is zero. New over the previous logic: parametrised channel and position width, held-button acceleration, and defined simultaneous-edge rules.

---
 rtl/paddle_emu_pkg.sv | 28 ++
 rtl/paddle_emu_ch.sv | 104 ++++++++++
 rtl/paddle_emu_mc.sv | 66 ++++++
 tb/tb_paddle_emu_mc.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_emu_pkg.sv
// paddle_emu shared types and helpers.
// Mode codes, held-button states and source-value alignment.
package paddle_emu_pkg;

   localparam logic [1:0] MODE_DIGITAL = 2'd0;
   localparam logic [1:0] MODE_Y       = 2'd1;
   localparam logic [1:0] MODE_X       = 2'd2;
   localparam logic [1:0] MODE_PADDLE  = 2'd3;

   localparam int PW_MAX = 10;

   typedef enum logic [1:0] {
      HELD_IDLE,
      HELD_UP,
      HELD_DOWN
   } held_e;

   // Optional offset-binary flip, then left-aligned in PW_MAX bits
   function automatic logic [PW_MAX-1:0] align_src(
      input logic [7:0] v,
      input logic       ofs
   );
      logic [7:0] s;
      s = ofs ? {~v[7], v[6:0]} : v;
      return {s, {(PW_MAX-8){1'b0}}};
   endfunction

endpackage

// File: rtl/paddle_emu_ch.sv
// paddle_emu_ch: one paddle channel.
// Digital position with held-button acceleration and a line countdown.
module paddle_emu_ch
   import paddle_emu_pkg::*;
#(
   parameter int PW           = 8,
   parameter int STEP_SLOW    = 5,
   parameter int STEP_FAST    = 8,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          hs_rise,
   input  logic          vs_rise,
   input  logic          speed,
   input  logic [1:0]    mode,
   input  logic          invert,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic [15:0]   analog,
   input  logic [7:0]    paddle,
   output logic          pin_out,
   output logic [PW-1:0] pos_out
);

   localparam int W = PW + 2;
   localparam logic [W-1:0] SLOW_W  = W'(STEP_SLOW);
   localparam logic [W-1:0] FAST_W  = W'(STEP_FAST);
   localparam logic [W-1:0] POS_MAX = W'((1 << PW) - 1);
   localparam logic [7:0]   ACC     = 8'(ACCEL_FRAMES);
   localparam int           SH      = PW_MAX - PW;

   held_e         held_q, held_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [PW-1:0] cd_q;
   logic [PW-1:0] ld_src;
   logic [W-1:0]  step, pos_x;

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         held_q <= HELD_IDLE;
         cnt_q  <= '0;
      end else if (vs_rise) begin
         held_q <= held_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      held_d = HELD_IDLE;
      cnt_d  = '0;
      case ({btn_up, btn_down})
         2'b10:   held_d = HELD_UP;
         2'b01:   held_d = HELD_DOWN;
         default: held_d = HELD_IDLE;
      endcase
      if (held_d != HELD_IDLE && held_d == held_q)
         cnt_d = (cnt_q >= ACC) ? ACC : cnt_q + 8'd1;
   end

   always_comb begin
      step = speed ? FAST_W : SLOW_W;
      if (ACCEL_FRAMES != 0 && cnt_d >= ACC)
         step = step << 1;
      pos_x = {2'b00, pos_q};
      pos_d = pos_q;
      case (held_d)
         HELD_UP:
            pos_d = (pos_x < step) ? '0 : PW'(pos_x - step);
         HELD_DOWN:
            pos_d = (pos_x + step > POS_MAX) ? '1 : PW'(pos_x + step);
         default: ;
      endcase
   end

   always_comb begin
      ld_src = pos_q;
      case (mode)
         MODE_Y:      ld_src = PW'(align_src(analog[15:8], 1'b1) >> SH);
         MODE_X:      ld_src = PW'(align_src(analog[7:0], 1'b1) >> SH);
         MODE_PADDLE: ld_src = PW'(align_src(paddle, 1'b0) >> SH);
         default:     ld_src = pos_q;
      endcase
   end

   // Frame edge wins over a coincident line edge
   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         pos_q <= PW'(1 << (PW - 1));
         cd_q  <= '0;
      end else if (vs_rise) begin
         if (mode == MODE_DIGITAL)
            pos_q <= pos_d;
         cd_q <= ld_src ^ {PW{invert}};
      end else if (hs_rise && cd_q != '0) begin
         cd_q <= cd_q - PW'(1);
      end
   end

   assign pin_out = (cd_q == '0);
   assign pos_out = pos_q;

endmodule

// File: rtl/paddle_emu_mc.sv
// paddle_emu_mc: multi-channel paddle emulator top.
// Shared sync edge detect feeding NCH channel instances.
module paddle_emu_mc
   import paddle_emu_pkg::*;
#(
   parameter int NCH          = 2,
   parameter int PW           = 8,
   parameter int STEP_SLOW    = 5,
   parameter int STEP_FAST    = 8,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              hs,
   input  logic              vs,
   input  logic              speed,
   input  logic [2*NCH-1:0]  mode,
   input  logic [NCH-1:0]    invert,
   input  logic [NCH-1:0]    btn_up,
   input  logic [NCH-1:0]    btn_down,
   input  logic [16*NCH-1:0] analog,
   input  logic [8*NCH-1:0]  paddle,
   output logic [NCH-1:0]    pin_out,
   output logic [PW*NCH-1:0] pos_out
);

   logic hs_q, vs_q;
   logic hs_rise, vs_rise;

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         hs_q <= 1'b0;
         vs_q <= 1'b0;
      end else begin
         hs_q <= hs;
         vs_q <= vs;
      end
   end

   assign hs_rise = hs & ~hs_q;
   assign vs_rise = vs & ~vs_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      paddle_emu_ch #(
         .PW          (PW),
         .STEP_SLOW   (STEP_SLOW),
         .STEP_FAST   (STEP_FAST),
         .ACCEL_FRAMES(ACCEL_FRAMES)
      ) u_ch (
         .clk_sys (clk_sys),
         .reset   (reset),
         .hs_rise (hs_rise),
         .vs_rise (vs_rise),
         .speed   (speed),
         .mode    (mode[2*i +: 2]),
         .invert  (invert[i]),
         .btn_up  (btn_up[i]),
         .btn_down(btn_down[i]),
         .analog  (analog[16*i +: 16]),
         .paddle  (paddle[8*i +: 8]),
         .pin_out (pin_out[i]),
         .pos_out (pos_out[PW*i +: PW])
      );
   end

endmodule

// File: tb/tb_paddle_emu_mc.sv
// Directed bench for paddle_emu_mc.
// Two instances: default NCH=2/PW=8 and NCH=1/PW=10.
module tb_paddle_emu_mc;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b0;
   logic        hs      = 1'b0;
   logic        vs      = 1'b0;
   logic        speed   = 1'b0;
   logic [3:0]  mode    = '0;
   logic [1:0]  invert  = '0;
   logic [1:0]  btn_up  = '0;
   logic [1:0]  btn_down = '0;
   logic [31:0] analog  = '0;
   logic [15:0] paddle  = '0;
   logic [1:0]  pin_out;
   logic [15:0] pos_out;

   logic [1:0]  mode10   = 2'd3;
   logic [0:0]  invert10 = '0;
   logic [0:0]  up10     = '0;
   logic [0:0]  dn10     = '0;
   logic [15:0] analog10 = '0;
   logic [7:0]  paddle10 = 8'h40;
   logic [0:0]  pin10;
   logic [9:0]  pos10;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   localparam int UP_EXP [13] = '{108, 103, 98, 93, 88, 78, 68,
                                  58, 48, 38, 28, 18, 8};
   localparam int DN_EXP [9]  = '{5, 10, 15, 20, 25, 30, 35, 40, 50};

   always #5 clk_sys = ~clk_sys;

   paddle_emu_mc u_dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .hs      (hs),
      .vs      (vs),
      .speed   (speed),
      .mode    (mode),
      .invert  (invert),
      .btn_up  (btn_up),
      .btn_down(btn_down),
      .analog  (analog),
      .paddle  (paddle),
      .pin_out (pin_out),
      .pos_out (pos_out)
   );

   paddle_emu_mc #(.NCH(1), .PW(10)) u_dut10 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .hs      (hs),
      .vs      (vs),
      .speed   (speed),
      .mode    (mode10),
      .invert  (invert10),
      .btn_up  (up10),
      .btn_down(dn10),
      .analog  (analog10),
      .paddle  (paddle10),
      .pin_out (pin10),
      .pos_out (pos10)
   );

   task automatic vs_pulse();
      @(negedge clk_sys) vs = 1'b1;
      @(negedge clk_sys) vs = 1'b0;
   endtask

   task automatic hs_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys) hs = 1'b1;
         @(negedge clk_sys) hs = 1'b0;
      end
   endtask

   task automatic both_pulse();
      @(negedge clk_sys) begin
         hs = 1'b1;
         vs = 1'b1;
      end
      @(negedge clk_sys) begin
         hs = 1'b0;
         vs = 1'b0;
      end
   endtask

   task automatic test_reset();
      #12;
      chk_cnt++;
      if (pin_out !== 2'b11)
         $display("FAIL rst_pin got %b want 11", pin_out);
      else pass_cnt++;
      chk_cnt++;
      if (pos_out !== 16'h8080)
         $display("FAIL rst_pos got %h want 8080", pos_out);
      else pass_cnt++;
      chk_cnt++;
      if (pos10 !== 10'd512 || pin10 !== 1'b1)
         $display("FAIL rst_pw10 got %0d/%b want 512/1", pos10, pin10);
      else pass_cnt++;
      @(negedge clk_sys) reset = 1'b1;
   endtask

   task automatic test_first_frame();
      vs_pulse();
      chk_cnt++;
      if (pin_out !== 2'b00)
         $display("FAIL ff_load got %b want 00", pin_out);
      else pass_cnt++;
      hs_pulses(127);
      chk_cnt++;
      if (pin_out !== 2'b00)
         $display("FAIL ff_127 got %b want 00", pin_out);
      else pass_cnt++;
      hs_pulses(1);
      chk_cnt++;
      if (pin_out !== 2'b11)
         $display("FAIL ff_128 got %b want 11", pin_out);
      else pass_cnt++;
   endtask

   task automatic test_digital_up();
      btn_up[0] = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd123)
         $display("FAIL up_f1 got %0d want 123", pos_out[7:0]);
      else pass_cnt++;
      vs_pulse();
      chk_cnt++;
      if (pos_out !== {8'd128, 8'd118})
         $display("FAIL up_f2 got %h want 8076", pos_out);
      else pass_cnt++;
      hs_pulses(122);
      chk_cnt++;
      if (pin_out[0] !== 1'b0)
         $display("FAIL up_cd122 got %b want 0", pin_out[0]);
      else pass_cnt++;
      hs_pulses(1);
      chk_cnt++;
      if (pin_out[0] !== 1'b1)
         $display("FAIL up_cd123 got %b want 1", pin_out[0]);
      else pass_cnt++;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd113)
         $display("FAIL up_f3 got %0d want 113", pos_out[7:0]);
      else pass_cnt++;
      for (int i = 0; i < 13; i++) begin
         vs_pulse();
         chk_cnt++;
         if (pos_out[7:0] !== 8'(UP_EXP[i]))
            $display("FAIL up_acc%0d got %0d want %0d",
                     i, pos_out[7:0], UP_EXP[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_saturation_low();
      btn_up[0] = 1'b0;
      vs_pulse();
      btn_up[0] = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd3)
         $display("FAIL sat_3 got %0d want 3", pos_out[7:0]);
      else pass_cnt++;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd0)
         $display("FAIL sat_0 got %0d want 0", pos_out[7:0]);
      else pass_cnt++;
      btn_up[0] = 1'b0;
      vs_pulse();
   endtask

   task automatic test_accel();
      btn_down[0] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         vs_pulse();
         chk_cnt++;
         if (pos_out[7:0] !== 8'(DN_EXP[i]))
            $display("FAIL acc_f%0d got %0d want %0d",
                     i + 1, pos_out[7:0], DN_EXP[i]);
         else pass_cnt++;
      end
      btn_down[0] = 1'b0;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd50)
         $display("FAIL acc_rel got %0d want 50", pos_out[7:0]);
      else pass_cnt++;
      btn_down[0] = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd55)
         $display("FAIL acc_restart got %0d want 55", pos_out[7:0]);
      else pass_cnt++;
   endtask

   task automatic test_saturation_high();
      speed = 1'b1;
      for (int i = 0; i < 30; i++) vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd255)
         $display("FAIL sat_255 got %0d want 255", pos_out[7:0]);
      else pass_cnt++;
      speed = 1'b0;
      btn_down[0] = 1'b0;
      btn_up[0] = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd250)
         $display("FAIL sat_250 got %0d want 250", pos_out[7:0]);
      else pass_cnt++;
      speed = 1'b1;
      btn_up[0] = 1'b0;
      btn_down[0] = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd255)
         $display("FAIL sat_fast got %0d want 255", pos_out[7:0]);
      else pass_cnt++;
      speed = 1'b0;
      btn_up[0] = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd255)
         $display("FAIL both got %0d want 255", pos_out[7:0]);
      else pass_cnt++;
      btn_down[0] = 1'b0;
      vs_pulse();
      chk_cnt++;
      if (pos_out[7:0] !== 8'd250)
         $display("FAIL both_next got %0d want 250", pos_out[7:0]);
      else pass_cnt++;
      btn_up[0] = 1'b0;
   endtask

   task automatic test_modes();
      mode[3:2] = 2'd1;
      analog[31:16] = {8'h80, 8'h7F};
      btn_down[1] = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pin_out[1] !== 1'b1 || pos_out[15:8] !== 8'd128)
         $display("FAIL y80 got %b/%0d want 1/128",
                  pin_out[1], pos_out[15:8]);
      else pass_cnt++;
      hs_pulses(3);
      chk_cnt++;
      if (pin_out[1] !== 1'b1)
         $display("FAIL y80_hold got %b want 1", pin_out[1]);
      else pass_cnt++;
      invert[1] = 1'b1;
      vs_pulse();
      hs_pulses(254);
      chk_cnt++;
      if (pin_out[1] !== 1'b0)
         $display("FAIL yinv_254 got %b want 0", pin_out[1]);
      else pass_cnt++;
      hs_pulses(1);
      chk_cnt++;
      if (pin_out[1] !== 1'b1)
         $display("FAIL yinv_255 got %b want 1", pin_out[1]);
      else pass_cnt++;
      invert[1] = 1'b0;
      btn_down[1] = 1'b0;
      mode[3:2] = 2'd2;
      vs_pulse();
      hs_pulses(254);
      chk_cnt++;
      if (pin_out[1] !== 1'b0)
         $display("FAIL x7f_254 got %b want 0", pin_out[1]);
      else pass_cnt++;
      hs_pulses(1);
      chk_cnt++;
      if (pin_out[1] !== 1'b1 || pin10 !== 1'b0)
         $display("FAIL x7f_255 got %b/%b want 1/0", pin_out[1], pin10);
      else pass_cnt++;
      hs_pulses(1);
      chk_cnt++;
      if (pin10 !== 1'b1)
         $display("FAIL pad_256 got %b want 1", pin10);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      mode[3:2] = 2'd3;
      paddle[15:8] = 8'd5;
      vs_pulse();
      paddle[15:8] = 8'd9;
      both_pulse();
      hs_pulses(8);
      chk_cnt++;
      if (pin_out[1] !== 1'b0)
         $display("FAIL sim_8 got %b want 0", pin_out[1]);
      else pass_cnt++;
      hs_pulses(1);
      chk_cnt++;
      if (pin_out[1] !== 1'b1)
         $display("FAIL sim_9 got %b want 1", pin_out[1]);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      vs_pulse();
      hs_pulses(3);
      @(negedge clk_sys) reset = 1'b0;
      #1;
      chk_cnt++;
      if (pin_out !== 2'b11 || pos_out !== 16'h8080)
         $display("FAIL mid_rst got %b/%h want 11/8080", pin_out, pos_out);
      else pass_cnt++;
      @(negedge clk_sys) reset = 1'b1;
      vs_pulse();
      chk_cnt++;
      if (pin_out !== 2'b00)
         $display("FAIL post_rst got %b want 00", pin_out);
      else pass_cnt++;
      hs_pulses(9);
      chk_cnt++;
      if (pin_out !== 2'b10)
         $display("FAIL post_rst9 got %b want 10", pin_out);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_digital_up();
      test_saturation_low();
      test_accel();
      test_saturation_high();
      test_modes();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
